risc_instr_fetch: RTL and testbench

Instruction fetch/issue unit for the 16-bit RISC processor: the producer end of the 16-bit instruction word consumed by the control, GPR and ALU control decoders. It owns the program counter and fetches words over a req/ack instruction-memory interface. It presents one instruction at a time with a valid/stall handshake and redirects on branch/jump requests from execute. It also flags an instruction-memory ack timeout.

---
 rtl/risc_instr_fetch_if.sv | 27 ++
 rtl/risc_instr_fetch.sv | 102 ++++++++++
 tb/tb_risc_instr_fetch.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_instr_fetch_if.sv
// Fetch-unit bus bundle: the instruction-memory req/ack port plus the
// instruction issue/redirect port toward the decoders and execute stage.
interface risc_instr_fetch_if;
    logic        o_imem_req;
    logic [15:0] o_imem_addr;
    logic        i_imem_ack;
    logic [15:0] i_imem_rdata;
    logic [15:0] o_instr;
    logic [15:0] o_instr_pc;
    logic        o_instr_valid;
    logic        i_stall;
    logic        i_branch_taken;
    logic [5:0]  i_offset;
    logic        i_jmp;
    logic [11:0] i_Joffset;
    logic        o_timeout;

    modport master (
        output o_imem_req, o_imem_addr, o_instr, o_instr_pc, o_instr_valid, o_timeout,
        input  i_imem_ack, i_imem_rdata, i_stall, i_branch_taken, i_offset, i_jmp, i_Joffset
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_instr, o_instr_pc, o_instr_valid, o_timeout,
        output i_imem_ack, i_imem_rdata, i_stall, i_branch_taken, i_offset, i_jmp, i_Joffset
    );
endinterface

// File: rtl/risc_instr_fetch.sv
// Instruction fetch/issue unit: owns the PC, fetches one word at a time over
// req/ack, presents it with valid/stall and redirects on branch/jump.
module risc_instr_fetch #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd64
) (
    input logic                i_clk,
    input logic                i_rst_n,
    risc_instr_fetch_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_e;

    localparam logic [15:0] PC_RST = {RESET_PC[15:1], 1'b0};

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [15:0] seq_pc;
    logic [15:0] br_target;
    logic [15:0] jmp_target;
    logic        redirect;

    // Both targets are relative to the word after the presented instruction.
    assign seq_pc     = instr_pc_q + 16'd2;
    assign br_target  = seq_pc + {{9{bus.i_offset[5]}}, bus.i_offset, 1'b0};
    assign jmp_target = {seq_pc[15:13], bus.i_Joffset, 1'b0};
    assign redirect   = bus.i_branch_taken | bus.i_jmp;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        timeout_d  = timeout_q;
        cnt_d      = '0;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (bus.i_imem_ack) begin
                    instr_d    = bus.i_imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 16'd2;
                    state_d    = S_HOLD;
                end else begin
                    // Saturate so the counter cannot wrap and re-fire on long waits.
                    cnt_d = (cnt_q == ACK_TIMEOUT) ? cnt_q : cnt_q + 8'd1;
                    if (cnt_d == ACK_TIMEOUT) timeout_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = bus.i_jmp ? jmp_target : br_target;
                    state_d = S_REQ;
                end else if (!bus.i_stall) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_d   = (state_d == S_REQ);
        valid_d = (state_d == S_HOLD);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_RST;
            instr_q    <= '0;
            instr_pc_q <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.o_imem_req    = req_q;
    assign bus.o_imem_addr   = pc_q;
    assign bus.o_instr       = instr_q;
    assign bus.o_instr_pc    = instr_pc_q;
    assign bus.o_instr_valid = valid_q;
    assign bus.o_timeout     = timeout_q;
endmodule

// File: tb/tb_risc_instr_fetch.sv
// Scoreboard bench for risc_instr_fetch: directed corner cases, then random
// memory latency, stalls and redirects against a transaction-level model.
module tb_risc_instr_fetch;
    localparam logic [15:0] RESET_PC    = 16'h0000;
    localparam int          ACK_TIMEOUT = 64;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    risc_instr_fetch_if bus();

    risc_instr_fetch #(.RESET_PC(RESET_PC), .ACK_TIMEOUT(8'(ACK_TIMEOUT))) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [32768];
    item_t       exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;

    // Transaction-level model state
    bit          m_boot, m_fetching, m_holding, exp_timeout;
    logic [15:0] exp_pc, cur_pc;
    int          wait_cnt;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] branch_target(input logic [15:0] ipc, input logic [5:0] off);
        return 16'(int'(ipc) + 2 + 2 * int'($signed(off)));
    endfunction

    function automatic logic [15:0] jump_target(input logic [15:0] ipc, input logic [11:0] f);
        logic [15:0] nxt;
        nxt = ipc + 16'd2;
        return {nxt[15:13], f, 1'b0};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_boot      = 1'b1;
        m_fetching  = 1'b0;
        m_holding   = 1'b0;
        exp_timeout = 1'b0;
        exp_pc      = {RESET_PC[15:1], 1'b0};
        cur_pc      = '0;
        wait_cnt    = 0;
    endtask

    // Drive one cycle's inputs just after a negedge, advance the model, wait for the next negedge.
    task automatic cycle(input bit ack, input bit stall, input bit br, input bit jmp,
                         input logic [5:0] off, input logic [11:0] joff);
        bus.i_imem_ack     = ack;
        bus.i_imem_rdata   = ack ? mem[bus.o_imem_addr[15:1]] : 16'($urandom);
        bus.i_stall        = stall;
        bus.i_branch_taken = br;
        bus.i_jmp          = jmp;
        bus.i_offset       = off;
        bus.i_Joffset      = joff;
        if (m_boot) begin
            m_boot     = 1'b0;
            m_fetching = 1'b1;
        end else if (m_fetching) begin
            if (ack) begin
                exp_q.push_back('{instr: mem[exp_pc[15:1]], pc: exp_pc});
                cur_pc     = exp_pc;
                exp_pc     = exp_pc + 16'd2;
                wait_cnt   = 0;
                m_fetching = 1'b0;
                m_holding  = 1'b1;
            end else begin
                wait_cnt++;
                if (wait_cnt >= ACK_TIMEOUT) exp_timeout = 1'b1;
            end
        end else if (m_holding) begin
            if (br || jmp) begin
                exp_pc     = jmp ? jump_target(cur_pc, joff) : branch_target(cur_pc, off);
                m_holding  = 1'b0;
                m_fetching = 1'b1;
            end else if (!stall) begin
                m_holding  = 1'b0;
                m_fetching = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic fetch();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 12'd0);
    endtask

    task automatic consume();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 12'd0);
    endtask

    task automatic do_reset();
        bus.i_imem_ack   = 1'b1;
        bus.i_imem_rdata = 16'hDEAD;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_req", {15'd0, bus.o_imem_req}, 16'd0);
        check("rst_valid", {15'd0, bus.o_instr_valid}, 16'd0);
        check("rst_instr", bus.o_instr, 16'h0000);
        check("rst_instr_pc", bus.o_instr_pc, 16'h0000);
        check("rst_addr", bus.o_imem_addr, RESET_PC);
        check("rst_timeout", {15'd0, bus.o_timeout}, 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: samples 2 ns after each rising edge, pops on each new instruction.
    item_t held;
    bit    prev_valid = 1'b0;
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else if (mon_en) begin
            check("mon_req", {15'd0, bus.o_imem_req}, {15'd0, m_fetching});
            check("mon_valid", {15'd0, bus.o_instr_valid}, {15'd0, m_holding});
            check("mon_timeout", {15'd0, bus.o_timeout}, {15'd0, exp_timeout});
            if (m_fetching) check("mon_addr", bus.o_imem_addr, exp_pc);
            if (bus.o_instr_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mon_pop: instruction %h presented with nothing expected", bus.o_instr);
                end else begin
                    held = exp_q.pop_front();
                    check("mon_instr", bus.o_instr, held.instr);
                    check("mon_instr_pc", bus.o_instr_pc, held.pc);
                end
            end else if (bus.o_instr_valid) begin
                check("mon_hold_instr", bus.o_instr, held.instr);
                check("mon_hold_pc", bus.o_instr_pc, held.pc);
            end
            prev_valid = bus.o_instr_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h2A58;
        rst_n = 1'b1;
        bus.i_imem_ack = 1'b0;
        bus.i_imem_rdata = '0;
        bus.i_stall = 1'b0;
        bus.i_branch_taken = 1'b0;
        bus.i_jmp = 1'b0;
        bus.i_offset = '0;
        bus.i_Joffset = '0;
        @(negedge clk);
        do_reset();
        mon_en = 1'b1;

        // First fetch: ack one cycle after req
        consume();
        check("boot_req", {15'd0, bus.o_imem_req}, 16'd1);
        fetch();
        check("first_instr", bus.o_instr, 16'h2A58);
        check("first_pc", bus.o_instr_pc, 16'h0000);
        check("first_valid", {15'd0, bus.o_instr_valid}, 16'd1);
        consume();
        check("second_addr", bus.o_imem_addr, 16'h0002);

        // Stall holds the instruction for 5 cycles
        fetch();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 12'd0);
            check("stall_instr", bus.o_instr, mem[1]);
            check("stall_valid", {15'd0, bus.o_instr_valid}, 16'd1);
            check("stall_req", {15'd0, bus.o_imem_req}, 16'd0);
        end
        consume();
        check("unstall_req", {15'd0, bus.o_imem_req}, 16'd1);
        check("unstall_addr", bus.o_imem_addr, 16'h0004);

        // Walk up to 0x0010, then branch back by two words (overriding a stall)
        for (int i = 0; i < 16 && exp_pc != 16'h0010; i++) begin
            fetch();
            consume();
        end
        fetch();
        check("br_src_pc", bus.o_instr_pc, 16'h0010);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 6'b111110, 12'd0);
        check("br_addr", bus.o_imem_addr, 16'h000E);
        check("br_valid", {15'd0, bus.o_instr_valid}, 16'd0);

        // Jumps to climb into the 0x4000 region, then jump-over-branch priority
        fetch();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 12'hFFF);
        check("jmp1_addr", bus.o_imem_addr, 16'h1FFE);
        fetch();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 12'hFFF);
        check("jmp2_addr", bus.o_imem_addr, 16'h3FFE);
        fetch();
        consume();
        fetch();
        check("jmp_src_pc", bus.o_instr_pc, 16'h4000);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 6'b000101, 12'h123);
        check("jmp_wins_addr", bus.o_imem_addr, 16'h4246);

        // Ack timeout: sets on the 64th waiting cycle and stays set
        repeat (ACK_TIMEOUT - 1) consume();
        check("timeout_before", {15'd0, bus.o_timeout}, 16'd0);
        consume();
        check("timeout_at", {15'd0, bus.o_timeout}, 16'd1);
        check("timeout_req_held", {15'd0, bus.o_imem_req}, 16'd1);
        fetch();
        check("timeout_after_ack", {15'd0, bus.o_timeout}, 16'd1);
        consume();
        check("timeout_sticky", {15'd0, bus.o_timeout}, 16'd1);

        // Reset while a request is outstanding; ack held high through reset and idle
        do_reset();
        fetch();
        check("post_rst_req", {15'd0, bus.o_imem_req}, 16'd1);
        check("post_rst_addr", bus.o_imem_addr, RESET_PC);
        check("post_rst_valid", {15'd0, bus.o_instr_valid}, 16'd0);
        fetch();
        check("post_rst_instr", bus.o_instr, 16'h2A58);

        // Branch backwards from 0x0000 wraps to 0xFFFE, then sequential wrap to 0x0000
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 6'b111110, 12'd0);
        check("wrap_br_addr", bus.o_imem_addr, 16'hFFFE);
        fetch();
        check("wrap_pc", bus.o_instr_pc, 16'hFFFE);
        consume();
        check("wrap_seq_addr", bus.o_imem_addr, 16'h0000);

        // Random latency, stalls, redirects (redirects also land outside hold to be ignored)
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  6'($urandom), 12'($urandom));
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 12'd0);
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
